// File: rtl/result_slot_allocator_pkg.sv
// Shared types and constants for the result-buffer slot allocator.
// Pure declarations: no logic, so it adds no latency and has no flow control.
package result_addr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        ADVANCE = 2'd2
    } state_t;

    localparam logic [31:0] ETH_SLOT_STRIDE   = 32'h060E;
    localparam int unsigned DEFAULT_NUM_SLOTS = 5;

endpackage

// File: rtl/result_slot_allocator_slot_pointer.sv
// Ring slot pointer: slot index plus byte address, stepped one stride per adv_i and wrapped after the last slot.
// Registered output that moves on the edge adv_i is sampled; clr_i wins over adv_i and applies no backpressure.
module slot_pointer #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] SLOT_STRIDE = '0,
    parameter int unsigned       NUM_SLOTS   = 5
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Incremental add plus index compare keeps the address path free of a multiplier.
    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        if (clr_i) begin
            idx_d  = '0;
            addr_d = BASE_ADDR;
        end else if (adv_i) begin
            if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                idx_d  = '0;
                addr_d = BASE_ADDR;
            end else begin
                idx_d  = idx_q + 1'b1;
                addr_d = addr_q + SLOT_STRIDE;
            end
        end
    end

    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        addr_q <= addr_d;
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/result_slot_allocator.sv
// Hands out ring slot addresses for matched frames, one strobed write per grant, and frees them oldest-first.
// Registered outputs; a held request yields one write every 2 cycles; a full ring refuses or overwrites per MODE_WRAP.
module result_slot_allocator
    import result_addr_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] SLOT_STRIDE = ADDR_W'(ETH_SLOT_STRIDE),
    parameter int unsigned       NUM_SLOTS   = DEFAULT_NUM_SLOTS,
    parameter bit                MODE_WRAP   = 1'b0
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             inc_addr,
    input  logic                             rel_slot,
    input  logic                             clear,
    output logic [ADDR_W-1:0]                addr_out,
    output logic                             write_enable,
    output logic [ADDR_W-1:0]                rd_addr,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   used_count,
    output logic                             full,
    output logic                             empty,
    output logic                             overflow
);

    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] used_q, used_d;
    logic             we_q, ov_q, ov_d, full_q, empty_q;
    logic             soft_rst, wr_done, rel_ok, grant_ok, overwrite;

    assign soft_rst  = !n_rst || clear;
    assign wr_done   = (state_q == WRITE);
    assign rel_ok    = rel_slot && !empty_q;
    assign grant_ok  = !full_q || MODE_WRAP;
    // A write into a full ring under wrap mode discards the oldest slot instead of growing.
    assign overwrite = wr_done && full_q && MODE_WRAP;

    always_comb begin
        used_d = used_q;
        if (wr_done && !rel_ok && !full_q) begin
            used_d = used_q + 1'b1;
        end else if (!wr_done && rel_ok) begin
            used_d = used_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ov_d    = 1'b0;
        case (state_q)
            IDLE, ADVANCE: begin
                state_d = IDLE;
                if (inc_addr) begin
                    if (grant_ok) begin
                        state_d = WRITE;
                    end else begin
                        ov_d = 1'b1;
                    end
                end
            end
            WRITE:   state_d = ADVANCE;
            default: state_d = IDLE;
        endcase
        // Flag the overwrite during the strobe cycle itself, judged on the occupancy it will see.
        if (MODE_WRAP && state_d == WRITE && used_d == CNT_W'(NUM_SLOTS)) begin
            ov_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q <= IDLE;
            used_q  <= '0;
            we_q    <= 1'b0;
            ov_q    <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            we_q    <= (state_d == WRITE);
            ov_q    <= ov_d;
            full_q  <= (used_d == CNT_W'(NUM_SLOTS));
            empty_q <= (used_d == '0);
        end
    end

    slot_pointer #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .SLOT_STRIDE (SLOT_STRIDE),
        .NUM_SLOTS   (NUM_SLOTS)
    ) u_head (
        .clk    (clk),
        .clr_i  (soft_rst),
        .adv_i  (wr_done),
        .addr_o (addr_out)
    );

    slot_pointer #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .SLOT_STRIDE (SLOT_STRIDE),
        .NUM_SLOTS   (NUM_SLOTS)
    ) u_tail (
        .clk    (clk),
        .clr_i  (soft_rst),
        .adv_i  (rel_ok || overwrite),
        .addr_o (rd_addr)
    );

    assign write_enable = we_q;
    assign used_count   = used_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign overflow     = ov_q;

endmodule

// File: tb/tb_result_slot_allocator.sv
// Drives a refusing (MODE_WRAP=0) and an overwriting (MODE_WRAP=1) allocator with the same stimulus.
// Writes are scoreboarded against a slot-level model; status outputs are compared every cycle.
module tb_result_slot_allocator;

    localparam int          NS   = 5;
    localparam logic [31:0] BASE = 32'h0000;
    localparam logic [31:0] STR  = 32'h060E;

    typedef struct packed {
        logic [31:0] addr;
        logic        ov;
    } wr_t;

    logic        clk = 1'b0;
    logic        n_rst, inc_addr, rel_slot, clear;
    logic [31:0] addr_o  [2];
    logic [31:0] rd_o    [2];
    logic [2:0]  used_o  [2];
    logic        we_o    [2];
    logic        full_o  [2];
    logic        empty_o [2];
    logic        ov_o    [2];

    always #5 clk = ~clk;

    result_slot_allocator #(.MODE_WRAP(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .inc_addr(inc_addr), .rel_slot(rel_slot), .clear(clear),
        .addr_out(addr_o[0]), .write_enable(we_o[0]), .rd_addr(rd_o[0]), .used_count(used_o[0]),
        .full(full_o[0]), .empty(empty_o[0]), .overflow(ov_o[0])
    );

    result_slot_allocator #(.MODE_WRAP(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst), .inc_addr(inc_addr), .rel_slot(rel_slot), .clear(clear),
        .addr_out(addr_o[1]), .write_enable(we_o[1]), .rd_addr(rd_o[1]), .used_count(used_o[1]),
        .full(full_o[1]), .empty(empty_o[1]), .overflow(ov_o[1])
    );

    // Model: phase 0 = waiting, 1 = strobing a write, 2 = recovering after a write.
    int  phase [2];
    int  head  [2];
    int  cnt   [2];
    bit  ovf   [2];
    wr_t exp0[$];
    wr_t exp1[$];
    wr_t got0, got1;
    int  checks = 0;
    int  errors = 0;

    function automatic logic [31:0] slot_addr(input int i);
        return BASE + 32'(i) * STR;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input int m, input bit wrap, input bit inc, input bit rel,
                              input bit clr, input bit rst);
        bit  was_full, wrote, rel_ok;
        int  occ;
        wr_t e;
        if (!rst || clr) begin
            phase[m] = 0; head[m] = 0; cnt[m] = 0; ovf[m] = 0;
            return;
        end
        was_full = (cnt[m] == NS);
        wrote    = (phase[m] == 1);
        rel_ok   = rel && cnt[m] > 0;
        ovf[m]   = 0;
        if (wrote) head[m] = (head[m] + 1) % NS;
        occ    = cnt[m] + (wrote ? 1 : 0) - (rel_ok ? 1 : 0);
        cnt[m] = (occ > NS) ? NS : occ;
        if (wrote) begin
            phase[m] = 2;
        end else if (inc && (!was_full || wrap)) begin
            phase[m] = 1;
            e.addr   = slot_addr(head[m]);
            e.ov     = wrap && (cnt[m] == NS);
            ovf[m]   = e.ov;
            if (m == 0) exp0.push_back(e); else exp1.push_back(e);
        end else begin
            phase[m] = 0;
            ovf[m]   = inc;
        end
    endtask

    task automatic check_status(input int m);
        string p;
        p = (m == 0) ? "refuse" : "wrap";
        check({p, "_addr_out"},     addr_o[m],         slot_addr(head[m]));
        check({p, "_rd_addr"},      rd_o[m],           slot_addr((head[m] - cnt[m] + NS) % NS));
        check({p, "_used_count"},   32'(used_o[m]),    32'(cnt[m]));
        check({p, "_full"},         32'(full_o[m]),    32'(cnt[m] == NS));
        check({p, "_empty"},        32'(empty_o[m]),   32'(cnt[m] == 0));
        check({p, "_overflow"},     32'(ov_o[m]),      32'(ovf[m]));
        check({p, "_write_enable"}, 32'(we_o[m]),      32'(phase[m] == 1));
    endtask

    task automatic cycle(input bit inc, input bit rel, input bit clr, input bit rst);
        inc_addr = inc; rel_slot = rel; clear = clr; n_rst = rst;
        @(posedge clk);
        model_step(0, 1'b0, inc, rel, clr, rst);
        model_step(1, 1'b1, inc, rel, clr, rst);
        #1;
        check_status(0);
        check_status(1);
    endtask

    // Hold a request until the refusing instance is strobing a write to slot `slot`.
    task automatic run_to_write(input int slot, input bit rel);
        int n;
        n = 0;
        while (!(phase[0] == 1 && head[0] == slot) && n < 40) begin
            cycle(1'b1, rel, 1'b0, 1'b1);
            n++;
        end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL run_to_write slot %0d: not reached within 40 cycles", slot);
        end
    endtask

    always @(negedge clk) begin
        if (we_o[0] === 1'b1) begin
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL refuse_unexpected_write at %0t: addr %h, none expected", $time, addr_o[0]);
            end else begin
                got0 = exp0.pop_front();
                check("refuse_write_addr", addr_o[0], got0.addr);
                check("refuse_write_ovf", 32'(ov_o[0]), 32'(got0.ov));
            end
        end
        if (we_o[1] === 1'b1) begin
            if (exp1.size() == 0) begin
                checks++; errors++;
                $display("FAIL wrap_unexpected_write at %0t: addr %h, none expected", $time, addr_o[1]);
            end else begin
                got1 = exp1.pop_front();
                check("wrap_write_addr", addr_o[1], got1.addr);
                check("wrap_write_ovf", 32'(ov_o[1]), 32'(got1.ov));
            end
        end
    end

    initial begin
        int rel_pct;
        for (int m = 0; m < 2; m++) begin
            phase[m] = 0; head[m] = 0; cnt[m] = 0; ovf[m] = 0;
        end
        inc_addr = 1'b0; rel_slot = 1'b0; clear = 1'b0; n_rst = 1'b0;

        // Reset held two cycles, then a long held request to fill past capacity.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 18; i++) cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        // Drain everything plus extra releases that must be ignored.
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 1);

        // Two slots filled, then three releases.
        cycle(0, 0, 1, 1);
        run_to_write(1, 1'b0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1);

        // Release coinciding with the write edge at occupancy 3.
        cycle(0, 0, 1, 1);
        run_to_write(3, 1'b0);
        cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 1);

        // Soft clear, then hard reset, each during a write to 0x0C1C with two slots used.
        cycle(0, 0, 1, 1);
        run_to_write(2, 1'b0);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        run_to_write(2, 1'b0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);

        // Randomized traffic with phases of light and heavy draining.
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) rel_pct = $urandom_range(5, 60);
            cycle($urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < rel_pct,
                  $urandom_range(0, 299) == 0,
                  $urandom_range(0, 499) != 0);
        end

        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        check("refuse_pending_writes", 32'(exp0.size()), 32'd0);
        check("wrap_pending_writes", 32'(exp1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
